// File: rtl/mem_arbiter.sv
// Arbitrates CPU instruction-fetch and data ports onto one single-ported memory via req/ack.
// Define MEM_ARB_IBUF_EN to add a one-entry fetch buffer that serves repeat fetches without memory.
module mem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_PRIO = 1,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic [31:0]       o_data_in_i,
  output logic              o_valid_i,
  input  logic [ADDR_W-1:0] i_addr_d,
  input  logic              i_rd_d,
  input  logic [3:0]        i_we_d,
  input  logic [31:0]       i_data_out_d,
  output logic [31:0]       o_data_in_d,
  output logic              o_valid_d,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  output logic [3:0]        o_mem_we,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata,
  input  logic              i_mem_ack,
  output logic              o_err
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StFetch, StData, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              last_data_q, last_data_d;
  logic              resp_data_q, resp_data_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [3:0]        mem_we_q, mem_we_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       data_i_q, data_i_d;
  logic [31:0]       data_d_q, data_d_d;

  logic data_req, store_req, grant_data, busy, timeout;
  logic ibuf_hit;
  logic [31:0] ibuf_data;

  assign store_req  = |i_we_d;
  assign data_req   = i_rd_d | store_req;
  // With alternation, fetch is always pending, so any data request is a conflict.
  assign grant_data = data_req & ((DATA_PRIO != 0) | ~last_data_q);
  assign busy       = (state_q == StFetch) || (state_q == StData);
  assign timeout    = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT));

`ifdef MEM_ARB_IBUF_EN
  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-3:0] buf_word_q, buf_word_d;
  logic [31:0]       buf_data_q, buf_data_d;

  assign ibuf_hit  = ~grant_data & buf_valid_q & (buf_word_q == i_addr_i[ADDR_W-1:2]);
  assign ibuf_data = buf_data_q;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_word_d  = buf_word_q;
    buf_data_d  = buf_data_q;
    if (busy && i_mem_ack && !resp_data_q) begin
      buf_valid_d = 1'b1;
      buf_word_d  = mem_addr_q[ADDR_W-1:2];
      buf_data_d  = i_mem_rdata;
    end else if (state_q == StIdle && grant_data && store_req &&
                 i_addr_d[ADDR_W-1:2] == buf_word_q) begin
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      buf_valid_q <= 1'b0;
      buf_word_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_word_q  <= buf_word_d;
      buf_data_q  <= buf_data_d;
    end
  end
`else
  assign ibuf_hit  = 1'b0;
  assign ibuf_data = '0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      last_data_q <= 1'b1;
      resp_data_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_we_q    <= '0;
      mem_wdata_q <= '0;
      data_i_q    <= '0;
      data_d_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_data_q <= last_data_d;
      resp_data_q <= resp_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      data_i_q    <= data_i_d;
      data_d_q    <= data_d_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (ibuf_hit)        state_d = StResp;
        else if (grant_data) state_d = StData;
        else                 state_d = StFetch;
      end
      StFetch, StData: begin
        // Ack beats a simultaneous timeout.
        if (i_mem_ack)    state_d = StResp;
        else if (timeout) state_d = StIdle;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    last_data_d = last_data_q;
    resp_data_d = resp_data_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = mem_rd_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    data_i_d    = data_i_q;
    data_d_d    = data_d_q;
    if (state_q == StIdle) begin
      cnt_d       = '0;
      last_data_d = grant_data;
      resp_data_d = grant_data;
      if (grant_data) begin
        mem_addr_d  = i_addr_d;
        mem_rd_d    = ~store_req;
        mem_we_d    = i_we_d;
        mem_wdata_d = store_req ? i_data_out_d : 32'h0;
      end else begin
        mem_addr_d  = i_addr_i;
        mem_rd_d    = 1'b1;
        mem_we_d    = '0;
        mem_wdata_d = 32'h0;
        if (ibuf_hit) data_i_d = ibuf_data;
      end
    end else if (busy) begin
      if (i_mem_ack) begin
        cnt_d = '0;
        if (resp_data_q) data_d_d = mem_rd_q ? i_mem_rdata : 32'h0;
        else             data_i_d = i_mem_rdata;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_comb begin
    o_mem_req = busy;
    o_mem_rd  = busy & mem_rd_q;
    o_mem_we  = busy ? mem_we_q : 4'h0;
    o_err     = busy & timeout & ~i_mem_ack;
    // A fetch whose address moved during flight is stale and is dropped silently.
    o_valid_i = (state_q == StResp) & ~resp_data_q & (mem_addr_q == i_addr_i);
    o_valid_d = (state_q == StResp) & resp_data_q & data_req;
  end

  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_data_in_i = data_i_q;
  assign o_data_in_d = data_d_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural reference model checked every cycle plus directed scenarios.
// Exercises the MEM_ARB_IBUF_EN fetch buffer when that macro is defined.
module tb_mem_arbiter;

  localparam int unsigned DataPrio = 1;
  localparam int unsigned Timeout  = 4;
  localparam int          Never    = 1000;
`ifdef MEM_ARB_IBUF_EN
  localparam bit IbufEn = 1'b1;
`else
  localparam bit IbufEn = 1'b0;
`endif
  localparam int SigVi = 0, SigVd = 1, SigReq = 2, SigErr = 3;

  logic        clk, rst_n;
  logic [31:0] addr_i, data_in_i, addr_d, data_out_d, data_in_d;
  logic        valid_i, rd_d, valid_d;
  logic [3:0]  we_d, mem_we;
  logic        mem_req, mem_rd, mem_ack, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_errors = 0;
  int ack_dly  = 2;

  logic [31:0] mem [logic [31:0]];

  mem_arbiter #(
    .ADDR_W   (32),
    .DATA_PRIO(DataPrio),
    .TIMEOUT  (Timeout)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_addr_i    (addr_i),
    .o_data_in_i (data_in_i),
    .o_valid_i   (valid_i),
    .i_addr_d    (addr_d),
    .i_rd_d      (rd_d),
    .i_we_d      (we_d),
    .i_data_out_d(data_out_d),
    .o_data_in_d (data_in_d),
    .o_valid_d   (valid_d),
    .o_mem_req   (mem_req),
    .o_mem_addr  (mem_addr),
    .o_mem_rd    (mem_rd),
    .o_mem_we    (mem_we),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata),
    .i_mem_ack   (mem_ack),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_5A5A);
  endfunction

  function automatic logic sig_now(input int which);
    case (which)
      SigVi:   return valid_i;
      SigVd:   return valid_d;
      SigReq:  return mem_req;
      default: return err;
    endcase
  endfunction

  // Waits (bounded) for a DUT strobe; n = number of negedges taken.
  task automatic wait_for(input string name, input int which, input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sig_now(which) && n < max);
    if (!sig_now(which)) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_%s: got no strobe, expected one within %0d cycles", name, max);
    end
  endtask

  // Memory responder: acks ack_dly cycles after o_mem_req rises, stores update the bench memory.
  initial begin : responder
    int  age;
    logic req_prev;
    logic [31:0] w;
    age = 0;
    req_prev = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = 32'hBAD0_BAD0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack   = 1'b0;
      mem_rdata = 32'hBAD0_BAD0;
      if (!rst_n) begin
        age = 0;
        req_prev = 1'b0;
      end else begin
        if (mem_req) age = req_prev ? age + 1 : 0;
        req_prev = mem_req;
        if (mem_req && age == ack_dly) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_read(mem_addr);
          if (mem_we != 4'h0) begin
            w = mem_read(mem_addr);
            for (int b = 0; b < 4; b++) if (mem_we[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            mem[mem_addr] = w;
          end
        end
      end
    end
  end

  // Reference model: tracks the outstanding transaction and predicts every output each cycle.
  initial begin : model
    logic        m_busy, m_resp, m_is_data, m_rd, m_last_data, m_buf_v, dreq, grant_d, exp_err;
    logic [31:0] m_addr, m_wdata, m_dout_i, m_dout_d, m_buf_d;
    logic [29:0] m_buf_w;
    logic [3:0]  m_we;
    int          m_wait;
    {m_busy, m_resp, m_is_data, m_rd, m_buf_v} = '0;
    m_last_data = 1'b1;
    {m_addr, m_wdata, m_dout_i, m_dout_d, m_buf_d} = '0;
    m_buf_w = '0;
    m_we = '0;
    m_wait = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_mem_req", mem_req, 0);
        chk("rst_valid_i", valid_i, 0);
        chk("rst_valid_d", valid_d, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_data_in_i", data_in_i, 0);
        chk("rst_data_in_d", data_in_d, 0);
        {m_busy, m_resp, m_buf_v} = '0;
        m_last_data = 1'b1;
        m_dout_i = '0;
        m_dout_d = '0;
      end else begin
        dreq    = rd_d || (we_d != 4'h0);
        exp_err = m_busy && (Timeout != 0) && (m_wait == Timeout) && !mem_ack;
        chk("mem_req", mem_req, m_busy);
        chk("mem_rd", mem_rd, m_busy && m_rd);
        chk("mem_we", mem_we, m_busy ? m_we : 4'h0);
        if (m_busy) chk("mem_addr", mem_addr, m_addr);
        if (m_busy && m_we != 4'h0) chk("mem_wdata", mem_wdata, m_wdata);
        chk("err", err, exp_err);
        chk("valid_i", valid_i, m_resp && !m_is_data && (m_addr == addr_i));
        chk("valid_d", valid_d, m_resp && m_is_data && dreq);
        chk("data_in_i", data_in_i, m_dout_i);
        chk("data_in_d", data_in_d, m_dout_d);
        if (m_resp) begin
          m_resp = 1'b0;
        end else if (m_busy) begin
          if (mem_ack) begin
            m_busy = 1'b0;
            m_resp = 1'b1;
            if (m_is_data) begin
              m_dout_d = (m_we != 4'h0) ? 32'h0 : mem_rdata;
            end else begin
              m_dout_i = mem_rdata;
              m_buf_v  = IbufEn;
              m_buf_w  = m_addr[31:2];
              m_buf_d  = mem_rdata;
            end
          end else if (exp_err) begin
            m_busy = 1'b0;
          end else begin
            m_wait++;
          end
        end else begin
          grant_d     = dreq && (DataPrio != 0 || !m_last_data);
          m_last_data = grant_d;
          m_is_data   = grant_d;
          m_wait      = 0;
          if (grant_d) begin
            m_addr  = addr_d;
            m_we    = we_d;
            m_rd    = (we_d == 4'h0);
            m_wdata = data_out_d;
            if (we_d != 4'h0 && addr_d[31:2] == m_buf_w) m_buf_v = 1'b0;
            m_busy = 1'b1;
          end else begin
            m_addr = addr_i;
            m_we   = 4'h0;
            m_rd   = 1'b1;
            if (m_buf_v && addr_i[31:2] == m_buf_w) begin
              m_resp   = 1'b1;
              m_dout_i = m_buf_d;
            end else begin
              m_busy = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: got still running, expected finish");
    $fatal(1, "bench did not terminate");
  end

  initial begin : stim
    int n, cnt;
    mem[32'h100]  = 32'h0000_0013;
    mem[32'h104]  = 32'h00A0_0093;
    mem[32'h200]  = 32'h0000_0513;
    mem[32'h2000] = 32'hCAFE_F00D;
    rst_n = 1'b0;
    addr_i = 32'h100;
    addr_d = 32'h0;
    rd_d = 1'b0;
    we_d = 4'h0;
    data_out_d = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req", mem_req, 0);
    chk("reset_valid_i", valid_i, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Plain fetch 0x100, ack two cycles after req.
    wait_for("req_fetch", SigReq, 10, n);
    chk("first_req_lat", n, 2);
    chk("fetch_addr", mem_addr, 32'h100);
    chk("fetch_rd", mem_rd, 1);
    wait_for("valid_fetch", SigVi, 10, n);
    chk("fetch_lat", n, 3);
    chk("fetch_data", data_in_i, 32'h0000_0013);
    @(posedge clk);
    #1;
    addr_i = 32'h104;
    rd_d   = 1'b1;
    addr_d = 32'h2000;
    @(negedge clk);
    chk("valid_i_one_cycle", valid_i, 0);

    // Simultaneous fetch and load: load wins.
    wait_for("valid_load", SigVd, 10, n);
    chk("load_data", data_in_d, 32'hCAFE_F00D);
    chk("load_first", valid_i, 0);
    @(posedge clk);
    #1 rd_d = 1'b0;
    wait_for("valid_fetch2", SigVi, 10, n);
    chk("fetch2_data", data_in_i, 32'h00A0_0093);

    // Store with rd also set is still a store.
    @(posedge clk);
    #1;
    we_d = 4'b0011;
    rd_d = 1'b1;
    addr_d = 32'h2004;
    data_out_d = 32'hDEAD_BEEF;
    wait_for("req_store", SigReq, 10, n);
    chk("back_to_back_gap", n, 2);
    chk("store_we", mem_we, 4'b0011);
    chk("store_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("store_rd", mem_rd, 0);
    chk("store_addr", mem_addr, 32'h2004);
    wait_for("valid_store", SigVd, 10, n);
    chk("store_data_in_d", data_in_d, 32'h0);
    @(posedge clk);
    #1;
    we_d = 4'h0;
    rd_d = 1'b0;

    // Fetch redirect during flight.
    wait_for("valid_pre_redirect", SigVi, 10, n);
    @(posedge clk);
    #1;
    addr_i  = 32'h108;
    ack_dly = 3;
    wait_for("req_108", SigReq, 10, n);
    chk("redirect_old_addr", mem_addr, 32'h108);
    @(posedge clk);
    #1 addr_i = 32'h200;
    cnt = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (valid_i) cnt++;
    end while (!(mem_req && mem_addr == 32'h200) && n < 20);
    chk("redirect_no_valid", cnt, 0);
    chk("redirect_new_addr", mem_addr, 32'h200);
    wait_for("valid_redirect", SigVi, 10, n);
    chk("redirect_data", data_in_i, 32'h0000_0513);

    // Watchdog: never ack.
    @(posedge clk);
    #1;
    ack_dly = Never;
    addr_i  = 32'h300;
    wait_for("req_timeout", SigReq, 10, n);
    chk("timeout_addr", mem_addr, 32'h300);
    wait_for("err", SigErr, 20, n);
    chk("err_lat", n, 4);
    @(negedge clk);
    chk("abort_req_drop", mem_req, 0);
    chk("err_one_cycle", err, 0);
    @(negedge clk);
    chk("rearb_req", mem_req, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_req", mem_req, 0);
    chk("async_rst_addr", mem_addr, 0);
    chk("async_rst_data_i", data_in_i, 0);
    chk("async_rst_err", err, 0);
    repeat (2) @(posedge clk);
    #1;
    ack_dly = 2;
    addr_i  = 32'h100;
    rst_n   = 1'b1;

    wait_for("valid_after_rst", SigVi, 10, n);
    chk("after_rst_data", data_in_i, 32'h0000_0013);
`ifdef MEM_ARB_IBUF_EN
    @(negedge clk);
    chk("ibuf_idle_req", mem_req, 0);
    @(negedge clk);
    chk("ibuf_hit_req", mem_req, 0);
    chk("ibuf_hit_valid", valid_i, 1);
    chk("ibuf_hit_data", data_in_i, 32'h0000_0013);
    @(posedge clk);
    #1;
    we_d = 4'hF;
    addr_d = 32'h100;
    data_out_d = 32'h1111_1111;
    wait_for("valid_ibuf_store", SigVd, 10, n);
    @(posedge clk);
    #1 we_d = 4'h0;
    wait_for("req_after_store", SigReq, 10, n);
    chk("refetch_addr", mem_addr, 32'h100);
    wait_for("valid_refetch", SigVi, 10, n);
    chk("refetch_data", data_in_i, 32'h1111_1111);
`else
    wait_for("req_repeat", SigReq, 10, n);
    chk("repeat_gap", n, 2);
    chk("repeat_addr", mem_addr, 32'h100);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-ported memory between the CPU instruction-fetch port and its data load/store port. It sits between `cpu` and the unified memory/cache. It serialises accesses through a req/ack handshake and returns per-port valid strobes matching the CPU's `i_valid_i` / `i_valid_d` semantics. A watchdog aborts transactions that never complete.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_PRIO, 1, 1 = data port wins simultaneous requests; 0 = strict alternation (last-granted loses).
- TIMEOUT, 255, cycles to wait for `i_mem_ack` before abort; 0 disables the watchdog.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_addr_i  in  ADDR_W  CPU fetch address; fetch request is implicitly always pending
- o_data_in_i  out  32  fetched instruction
- o_valid_i  out  1  one-cycle strobe: o_data_in_i valid for the current i_addr_i
- i_addr_d  in  ADDR_W  CPU data address
- i_rd_d  in  1  load request
- i_we_d  in  4  byte write enables (store request if any set)
- i_data_out_d  in  32  store data
- o_data_in_d  out  32  load data
- o_valid_d  out  1  one-cycle strobe: load data returned / store done
- o_mem_req  out  1  memory request, held until ack
- o_mem_addr  out  ADDR_W  memory address, stable while o_mem_req
- o_mem_rd  out  1  read transaction
- o_mem_we  out  4  byte enables for write transaction
- o_mem_wdata  out  32  write data, stable while o_mem_req
- i_mem_rdata  in  32  read data, valid in the ack cycle
- i_mem_ack  in  1  single-cycle completion
- o_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async, `i_rst_n` = 0):
  - State IDLE.
  - All outputs 0.
  - Watchdog counter 0.
  - Last-grant = data.
- States:
  - IDLE: sample requests; grant; register memory outputs → FETCH or DATA next cycle.
  - FETCH / DATA: `o_mem_req` = 1, memory outputs frozen; wait for `i_mem_ack` → RESP.
  - RESP: drive the selected valid strobe for one cycle → IDLE.
- Grant rules:
  - Data request = `i_rd_d` | (|`i_we_d`).
  - DATA_PRIO = 1: data is granted whenever a data request is present.
  - DATA_PRIO = 0: on a conflict the port not granted last wins.
- Latency: request seen in IDLE at cycle N; `o_mem_req` from N+1; ack at cycle M ≥ N+1; valid strobe at M+1. Minimum 3 cycles per access. Back-to-back accesses have one IDLE cycle between them.
- Memory address:
  - `o_mem_addr` = full byte address.
  - Store: `o_mem_wdata` = `i_data_out_d` unmodified, `o_mem_we` = `i_we_d`, `o_mem_rd` = 0.
  - Load: `o_mem_rd` = 1, `o_mem_we` = 0.
  - A request with both `i_rd_d` and `i_we_d` set is treated as a store.
- Read data capture: `i_mem_rdata` is registered into `o_data_in_i` / `o_data_in_d` on the ack cycle. Data outputs hold their value between strobes. `o_data_in_d` is 0 after a store.
- Fetch redirect:
  - Captured fetch address is compared to `i_addr_i` in RESP.
  - On mismatch (branch during the flight): `o_valid_i` is suppressed, the result is discarded, and the arbiter returns to IDLE. A new fetch follows.
- Data withdrawal: if the data request drops mid-flight, the memory transaction still completes. `o_valid_d` is suppressed if the request is absent in RESP.
- Watchdog:
  - Counter runs in FETCH/DATA and clears on ack.
  - At count == TIMEOUT: `o_mem_req` drops, `o_err` pulses, no valid strobe, state → IDLE. The request is re-arbitrated.
- Ack outside FETCH/DATA is ignored.
- `i_mem_ack` in the same cycle as the timeout: ack wins.

Optional Feature:
- Macro: MEM_ARB_IBUF_EN.
- Defined:
  - A one-entry fetch buffer holds {word address, data, valid} from the last completed fetch.
  - In IDLE with no granted data request, `i_addr_i[ADDR_W-1:2]` matching the buffer → `o_valid_i` next cycle with the buffered data, no memory access.
  - Any granted store whose word address matches clears the buffer valid bit.
  - Reset clears the buffer.
- Undefined: no buffer logic; every fetch goes to memory.

Test Plan:
- Fetch 0x100, ack 2 cycles after req with rdata 0x00000013 → `o_mem_addr` = 0x100, `o_mem_rd` = 1; `o_valid_i` = 1 and `o_data_in_i` = 0x00000013 for exactly 1 cycle, 1 cycle after ack.
- Fetch 0x104 plus load 0x2000 in the same cycle, DATA_PRIO = 1, rdata 0xCAFEF00D then 0x00A00093 → load served first (`o_valid_d`, `o_data_in_d` = 0xCAFEF00D), then fetch (`o_data_in_i` = 0x00A00093).
- Store `i_we_d` = 4'b0011, data 0xDEADBEEF at 0x2004 → `o_mem_we` = 0011, `o_mem_wdata` = 0xDEADBEEF, `o_mem_rd` = 0, `o_valid_d` pulse, `o_data_in_d` = 0.
- Fetch 0x108 in flight, `i_addr_i` changes to 0x200 before ack → no `o_valid_i` for 0x108; next `o_mem_addr` = 0x200 and its data is returned with `o_valid_i`.
- TIMEOUT = 4, no ack → `o_err` pulse 4 cycles after req start, `o_mem_req` drops, re-request follows. Assert `i_rst_n` = 0 mid-flight → all outputs 0 immediately.
- MEM_ARB_IBUF_EN: fetch 0x100 twice → second access has no `o_mem_req` and `o_valid_i` after 1 cycle. Store to 0x100, then fetch 0x100 → memory accessed again.
